tx_port_channel_writer_128: RTL and testbench

Producer side of the TX port event stream: converts a 128-bit user channel TX interface (CHNL_TX/LEN/OFF/LAST handshake plus data beats) into the tagged event/payload stream written into the event FIFO. It emits two open events carrying the transaction parameters, the payload words, then two close events. The TX port monitor drains this stream from the FIFO's far end.

---
 rtl/tx_port_pkg.sv | 47 ++++
 rtl/tx_port_channel_writer_128.sv | 114 +++++++++++
 tb/tb_tx_port_channel_writer_128.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_port_pkg.sv
// Shared constants for the TX port event stream: FSM encoding and event word layout.
// The producer (channel writer) and the consumer (port monitor) both rely on this layout.
package tx_port_pkg;

  // One-hot FSM encoding for the channel writer.
  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_OPEN_0  = 6'b000010,
    S_OPEN_1  = 6'b000100,
    S_DATA    = 6'b001000,
    S_CLOSE_0 = 6'b010000,
    S_CLOSE_1 = 6'b100000
  } tx_state_t;

  localparam int EVT_FLAG_BIT = 128;
  localparam int EVT_W        = EVT_FLAG_BIT + 1;
  localparam int PARAM_W      = 64;
  localparam int LEN_W        = 32;
  localparam int OFF_W        = 31;
  localparam int LEN_LSB      = 32;
  localparam int OFF_LSB      = 1;
  localparam int LAST_BIT     = 0;
  localparam int WORDS_PER_BEAT = 4;

  // Transaction parameters as carried in the low 64 bits of every event word.
  function automatic logic [PARAM_W-1:0] pack_param(
    input logic [LEN_W-1:0] len,
    input logic [OFF_W-1:0] off,
    input logic             last
  );
    logic [PARAM_W-1:0] p;
    p                     = '0;
    p[LEN_LSB +: LEN_W]   = len;
    p[OFF_LSB +: OFF_W]   = off;
    p[LAST_BIT]           = last;
    return p;
  endfunction

  function automatic logic [EVT_W-1:0] event_word(input logic [PARAM_W-1:0] p);
    logic [EVT_W-1:0] w;
    w                  = '0;
    w[EVT_FLAG_BIT]    = 1'b1;
    w[PARAM_W-1:0]     = p;
    return w;
  endfunction

endpackage

// File: rtl/tx_port_channel_writer_128.sv
// Producer side of the TX port event stream: turns a 128-bit channel TX transaction
// into open events, payload words and close events written into the event FIFO.
module tx_port_channel_writer_128
  import tx_port_pkg::*;
#(
  parameter int C_DATA_WIDTH = 128
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    CHNL_TX,
  output logic                    CHNL_TX_ACK,
  input  logic                    CHNL_TX_LAST,
  input  logic [31:0]             CHNL_TX_LEN,
  input  logic [30:0]             CHNL_TX_OFF,
  input  logic [C_DATA_WIDTH-1:0] CHNL_TX_DATA,
  input  logic                    CHNL_TX_DATA_VALID,
  output logic                    CHNL_TX_DATA_REN,
  output logic [C_DATA_WIDTH:0]   EVT_DATA,
  output logic                    EVT_WR_EN,
  input  logic                    EVT_FULL,
  output logic [31:0]             WORDS_SENT
);

  tx_state_t          state;
  logic [PARAM_W-1:0] param_r;
  logic [31:0]        words_sent_r;
  logic               beat;
  logic               wr_en;
  logic               ack;
  logic               ren;
  logic [EVT_W-1:0]   evt_data;

  // Write strobe, ACK and REN are decoded straight from state so a write lands in the
  // same cycle the state is entered or the beat is accepted; RST gates them all low.
  always_comb begin
    wr_en    = 1'b0;
    ack      = 1'b0;
    ren      = 1'b0;
    beat     = 1'b0;
    evt_data = event_word(param_r);
    if (!RST) begin
      case (state)
        S_OPEN_0, S_CLOSE_0, S_CLOSE_1: begin
          wr_en = !EVT_FULL;
        end
        S_OPEN_1: begin
          wr_en = !EVT_FULL;
          ack   = !EVT_FULL;
        end
        S_DATA: begin
          ren   = !EVT_FULL;
          beat  = CHNL_TX_DATA_VALID && !EVT_FULL;
          wr_en = beat;
          if (beat) begin
            evt_data = {1'b0, CHNL_TX_DATA};
          end
        end
        default: begin
          wr_en = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= S_IDLE;
      param_r      <= '0;
      words_sent_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (CHNL_TX) begin
            param_r <= pack_param(CHNL_TX_LEN, CHNL_TX_OFF, CHNL_TX_LAST);
            state   <= S_OPEN_0;
          end
        end
        S_OPEN_0: begin
          if (!EVT_FULL) state <= S_OPEN_1;
        end
        S_OPEN_1: begin
          if (!EVT_FULL) begin
            words_sent_r <= '0;
            state        <= S_DATA;
          end
        end
        S_DATA: begin
          // An accepted beat wins over a falling CHNL_TX; the close waits a cycle.
          if (beat) begin
            words_sent_r <= words_sent_r + 32'(WORDS_PER_BEAT);
          end else if (!CHNL_TX) begin
            state <= S_CLOSE_0;
          end
        end
        S_CLOSE_0: begin
          if (!EVT_FULL) state <= S_CLOSE_1;
        end
        S_CLOSE_1: begin
          if (!EVT_FULL) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign CHNL_TX_ACK      = ack;
  assign CHNL_TX_DATA_REN = ren;
  assign EVT_WR_EN        = wr_en;
  assign EVT_DATA         = evt_data;
  assign WORDS_SENT       = words_sent_r;

endmodule

// File: tb/tb_tx_port_channel_writer_128.sv
// Directed bench for tx_port_channel_writer_128: logs every FIFO write and ACK pulse
// and compares against hand-computed event/payload sequences per scenario.
module tb_tx_port_channel_writer_128;

  logic         CLK;
  logic         RST;
  logic         CHNL_TX;
  logic         CHNL_TX_ACK;
  logic         CHNL_TX_LAST;
  logic [31:0]  CHNL_TX_LEN;
  logic [30:0]  CHNL_TX_OFF;
  logic [127:0] CHNL_TX_DATA;
  logic         CHNL_TX_DATA_VALID;
  logic         CHNL_TX_DATA_REN;
  logic [128:0] EVT_DATA;
  logic         EVT_WR_EN;
  logic         EVT_FULL;
  logic [31:0]  WORDS_SENT;

  int total;
  int bad;
  int ack_cnt;
  logic [128:0] wr_log[$];

  localparam logic [127:0] D0 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
  localparam logic [127:0] D1 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D2 = 128'haaaa_5555_aaaa_5555_aaaa_5555_aaaa_5555;
  localparam logic [127:0] D3 = 128'h8000_0000_0000_0000_0000_0000_0000_0001;

  localparam logic [128:0] EVT_BASIC = {1'b1, 64'd0, 64'h0000_0008_0000_0001};
  localparam logic [128:0] EVT_STALL = {1'b1, 64'd0, 64'h0000_0010_0000_000A};
  localparam logic [128:0] EVT_FALL  = {1'b1, 64'd0, 64'h0000_000C_0000_0006};
  localparam logic [128:0] EVT_LEN0  = {1'b1, 64'd0, 64'h0000_0000_FFFF_FFFF};
  localparam logic [128:0] EVT_RST   = {1'b1, 64'd0, 64'h0000_0040_0000_0000};
  localparam logic [128:0] EVT_RST2  = {1'b1, 64'd0, 64'h0000_0004_0000_0002};
  localparam logic [128:0] EVT_B2B_A = {1'b1, 64'd0, 64'h0000_0020_0000_0200};
  localparam logic [128:0] EVT_B2B_B = {1'b1, 64'd0, 64'h1234_5678_5555_5555};

  tx_port_channel_writer_128 #(.C_DATA_WIDTH(128)) dut (
    .CLK                (CLK),
    .RST                (RST),
    .CHNL_TX            (CHNL_TX),
    .CHNL_TX_ACK        (CHNL_TX_ACK),
    .CHNL_TX_LAST       (CHNL_TX_LAST),
    .CHNL_TX_LEN        (CHNL_TX_LEN),
    .CHNL_TX_OFF        (CHNL_TX_OFF),
    .CHNL_TX_DATA       (CHNL_TX_DATA),
    .CHNL_TX_DATA_VALID (CHNL_TX_DATA_VALID),
    .CHNL_TX_DATA_REN   (CHNL_TX_DATA_REN),
    .EVT_DATA           (EVT_DATA),
    .EVT_WR_EN          (EVT_WR_EN),
    .EVT_FULL           (EVT_FULL),
    .WORDS_SENT         (WORDS_SENT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (EVT_WR_EN) wr_log.push_back(EVT_DATA);
    if (CHNL_TX_ACK) ack_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    wr_log.delete();
    ack_cnt = 0;
  endtask

  task automatic set_params(input logic [31:0] len, input logic [30:0] off, input logic last);
    CHNL_TX_LEN  = len;
    CHNL_TX_OFF  = off;
    CHNL_TX_LAST = last;
  endtask

  task automatic test_reset();
    RST = 1'b1; CHNL_TX = 1'b1; CHNL_TX_DATA_VALID = 1'b1; CHNL_TX_DATA = D0;
    set_params(32'd8, 31'd0, 1'b1);
    tick(2);
    total++; if (EVT_WR_EN !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%b want=0", EVT_WR_EN); end
    total++; if (CHNL_TX_ACK !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", CHNL_TX_ACK); end
    total++; if (CHNL_TX_DATA_REN !== 1'b0) begin bad++; $display("FAIL reset_ren got=%b want=0", CHNL_TX_DATA_REN); end
    total++; if (WORDS_SENT !== 32'd0) begin bad++; $display("FAIL reset_words got=%0d want=0", WORDS_SENT); end
    CHNL_TX = 1'b0; CHNL_TX_DATA_VALID = 1'b0;
    tick(1);
    RST = 1'b0;
    tick(2);
    total++; if (EVT_WR_EN !== 1'b0 || CHNL_TX_DATA_REN !== 1'b0) begin bad++; $display("FAIL idle_quiet got wr=%b ren=%b want 0/0", EVT_WR_EN, CHNL_TX_DATA_REN); end
    total++; if (wr_log.size() !== 0) begin bad++; $display("FAIL reset_no_writes got=%0d want=0", wr_log.size()); end
  endtask

  task automatic test_basic();
    clear_log();
    set_params(32'd8, 31'd0, 1'b1); CHNL_TX = 1'b1;
    tick(1); #1;
    total++; if (EVT_WR_EN !== 1'b1 || EVT_DATA !== EVT_BASIC) begin bad++; $display("FAIL basic_open0 got wr=%b data=%h want wr=1 data=%h", EVT_WR_EN, EVT_DATA, EVT_BASIC); end
    total++; if (CHNL_TX_ACK !== 1'b0) begin bad++; $display("FAIL basic_ack_early got=%b want=0", CHNL_TX_ACK); end
    tick(1); #1;
    total++; if (CHNL_TX_ACK !== 1'b1 || EVT_WR_EN !== 1'b1) begin bad++; $display("FAIL basic_open1 got ack=%b wr=%b want 1/1", CHNL_TX_ACK, EVT_WR_EN); end
    tick(1);
    CHNL_TX_DATA_VALID = 1'b1; CHNL_TX_DATA = D0; #1;
    total++; if (CHNL_TX_DATA_REN !== 1'b1 || CHNL_TX_ACK !== 1'b0) begin bad++; $display("FAIL basic_data_entry got ren=%b ack=%b want 1/0", CHNL_TX_DATA_REN, CHNL_TX_ACK); end
    total++; if (EVT_DATA !== {1'b0, D0}) begin bad++; $display("FAIL basic_payload0 got=%h want=%h", EVT_DATA, {1'b0, D0}); end
    tick(1);
    CHNL_TX_DATA = D1;
    total++; if (WORDS_SENT !== 32'd4) begin bad++; $display("FAIL basic_words1 got=%0d want=4", WORDS_SENT); end
    tick(1);
    CHNL_TX_DATA_VALID = 1'b0; CHNL_TX = 1'b0;
    total++; if (WORDS_SENT !== 32'd8) begin bad++; $display("FAIL basic_words2 got=%0d want=8", WORDS_SENT); end
    tick(3);
    total++; if (wr_log.size() !== 6) begin bad++; $display("FAIL basic_count got=%0d want=6", wr_log.size()); end
    total++; if (wr_log[0] !== EVT_BASIC || wr_log[1] !== EVT_BASIC) begin bad++; $display("FAIL basic_opens got=%h %h want=%h", wr_log[0], wr_log[1], EVT_BASIC); end
    total++; if (wr_log[2] !== {1'b0, D0} || wr_log[3] !== {1'b0, D1}) begin bad++; $display("FAIL basic_payload got=%h %h want=%h %h", wr_log[2], wr_log[3], {1'b0, D0}, {1'b0, D1}); end
    total++; if (wr_log[4] !== EVT_BASIC || wr_log[5] !== EVT_BASIC) begin bad++; $display("FAIL basic_closes got=%h %h want=%h", wr_log[4], wr_log[5], EVT_BASIC); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL basic_ack_count got=%0d want=1", ack_cnt); end
  endtask

  task automatic test_full_stall();
    clear_log();
    set_params(32'd16, 31'd5, 1'b0); CHNL_TX = 1'b1;
    tick(2);
    EVT_FULL = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (EVT_WR_EN !== 1'b0 || CHNL_TX_ACK !== 1'b0) begin bad++; $display("FAIL stall_hold%0d got wr=%b ack=%b want 0/0", i, EVT_WR_EN, CHNL_TX_ACK); end
      if (i < 2) begin tick(1); #1; end
    end
    tick(1);
    EVT_FULL = 1'b0; #1;
    total++; if (CHNL_TX_ACK !== 1'b1 || EVT_WR_EN !== 1'b1) begin bad++; $display("FAIL stall_resume got ack=%b wr=%b want 1/1", CHNL_TX_ACK, EVT_WR_EN); end
    tick(1);
    CHNL_TX = 1'b0;
    tick(4);
    total++; if (wr_log.size() !== 4) begin bad++; $display("FAIL stall_count got=%0d want=4", wr_log.size()); end
    total++; if (wr_log[0] !== EVT_STALL || wr_log[1] !== EVT_STALL || wr_log[2] !== EVT_STALL || wr_log[3] !== EVT_STALL) begin bad++; $display("FAIL stall_events got=%h %h want=%h", wr_log[0], wr_log[3], EVT_STALL); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL stall_ack_count got=%0d want=1", ack_cnt); end
  endtask

  task automatic test_fall_with_beat();
    clear_log();
    set_params(32'd12, 31'd3, 1'b0); CHNL_TX = 1'b1;
    tick(3);
    EVT_FULL = 1'b1; CHNL_TX_DATA_VALID = 1'b1; CHNL_TX_DATA = D2; #1;
    total++; if (CHNL_TX_DATA_REN !== 1'b0 || EVT_WR_EN !== 1'b0) begin bad++; $display("FAIL fall_full_hold got ren=%b wr=%b want 0/0", CHNL_TX_DATA_REN, EVT_WR_EN); end
    tick(1);
    EVT_FULL = 1'b0; #1;
    total++; if (CHNL_TX_DATA_REN !== 1'b1 || EVT_WR_EN !== 1'b1 || EVT_DATA !== {1'b0, D2}) begin bad++; $display("FAIL fall_beat0 got ren=%b wr=%b data=%h want 1/1 %h", CHNL_TX_DATA_REN, EVT_WR_EN, EVT_DATA, {1'b0, D2}); end
    tick(1);
    CHNL_TX_DATA = D3; CHNL_TX = 1'b0; #1;
    total++; if (EVT_WR_EN !== 1'b1) begin bad++; $display("FAIL fall_beat1 got wr=%b want 1", EVT_WR_EN); end
    tick(1);
    CHNL_TX_DATA_VALID = 1'b0; #1;
    total++; if (EVT_WR_EN !== 1'b0) begin bad++; $display("FAIL fall_no_early_close got wr=%b want 0", EVT_WR_EN); end
    tick(4);
    total++; if (wr_log.size() !== 6) begin bad++; $display("FAIL fall_count got=%0d want=6", wr_log.size()); end
    total++; if (wr_log[2] !== {1'b0, D2} || wr_log[3] !== {1'b0, D3}) begin bad++; $display("FAIL fall_payload got=%h %h want=%h %h", wr_log[2], wr_log[3], {1'b0, D2}, {1'b0, D3}); end
    total++; if (wr_log[4] !== EVT_FALL || wr_log[5] !== EVT_FALL) begin bad++; $display("FAIL fall_closes got=%h %h want=%h", wr_log[4], wr_log[5], EVT_FALL); end
    total++; if (WORDS_SENT !== 32'd8) begin bad++; $display("FAIL fall_words got=%0d want=8", WORDS_SENT); end
  endtask

  task automatic test_len_zero();
    clear_log();
    set_params(32'd0, 31'h7FFF_FFFF, 1'b1); CHNL_TX = 1'b1;
    tick(3);
    CHNL_TX = 1'b0; #1;
    total++; if (CHNL_TX_DATA_REN !== 1'b1) begin bad++; $display("FAIL len0_data_state got ren=%b want 1", CHNL_TX_DATA_REN); end
    tick(4);
    total++; if (wr_log.size() !== 4) begin bad++; $display("FAIL len0_count got=%0d want=4", wr_log.size()); end
    total++; if (wr_log[0] !== EVT_LEN0 || wr_log[1] !== EVT_LEN0 || wr_log[2] !== EVT_LEN0 || wr_log[3] !== EVT_LEN0) begin bad++; $display("FAIL len0_events got=%h %h want=%h", wr_log[0], wr_log[3], EVT_LEN0); end
    total++; if (WORDS_SENT !== 32'd0) begin bad++; $display("FAIL len0_words got=%0d want=0", WORDS_SENT); end
    total++; if (ack_cnt !== 1) begin bad++; $display("FAIL len0_ack_count got=%0d want=1", ack_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    set_params(32'd64, 31'd0, 1'b0); CHNL_TX = 1'b1;
    tick(3);
    CHNL_TX_DATA_VALID = 1'b1; CHNL_TX_DATA = D0;
    tick(1); CHNL_TX_DATA = D1;
    tick(1); CHNL_TX_DATA = D2;
    tick(1);
    total++; if (WORDS_SENT !== 32'd12) begin bad++; $display("FAIL rstmid_words_pre got=%0d want=12", WORDS_SENT); end
    RST = 1'b1; CHNL_TX_DATA = D3; #1;
    total++; if (EVT_WR_EN !== 1'b0 || CHNL_TX_DATA_REN !== 1'b0) begin bad++; $display("FAIL rstmid_gate got wr=%b ren=%b want 0/0", EVT_WR_EN, CHNL_TX_DATA_REN); end
    tick(1);
    RST = 1'b0; CHNL_TX = 1'b0; CHNL_TX_DATA_VALID = 1'b0; #1;
    total++; if (WORDS_SENT !== 32'd0) begin bad++; $display("FAIL rstmid_words_post got=%0d want=0", WORDS_SENT); end
    tick(3);
    total++; if (wr_log.size() !== 5) begin bad++; $display("FAIL rstmid_count got=%0d want=5", wr_log.size()); end
    total++; if (wr_log[0] !== EVT_RST || wr_log[4] !== {1'b0, D2}) begin bad++; $display("FAIL rstmid_log got=%h %h want=%h %h", wr_log[0], wr_log[4], EVT_RST, {1'b0, D2}); end
    total++; if (EVT_WR_EN !== 1'b0 || CHNL_TX_DATA_REN !== 1'b0) begin bad++; $display("FAIL rstmid_idle got wr=%b ren=%b want 0/0", EVT_WR_EN, CHNL_TX_DATA_REN); end
    clear_log();
    set_params(32'd4, 31'd1, 1'b0); CHNL_TX = 1'b1;
    tick(1); #1;
    total++; if (EVT_WR_EN !== 1'b1 || EVT_DATA !== EVT_RST2) begin bad++; $display("FAIL rstmid_restart got wr=%b data=%h want 1 %h", EVT_WR_EN, EVT_DATA, EVT_RST2); end
    tick(2);
    CHNL_TX = 1'b0;
    tick(4);
    total++; if (wr_log.size() !== 4 || ack_cnt !== 1) begin bad++; $display("FAIL rstmid_second got writes=%0d acks=%0d want 4/1", wr_log.size(), ack_cnt); end
  endtask

  task automatic test_back_to_back();
    clear_log();
    set_params(32'd32, 31'h100, 1'b0); CHNL_TX = 1'b1;
    tick(3);
    CHNL_TX_DATA_VALID = 1'b1; CHNL_TX_DATA = D0; CHNL_TX = 1'b0;
    tick(1);
    CHNL_TX_DATA_VALID = 1'b0;
    tick(3);
    set_params(32'h1234_5678, 31'h2AAA_AAAA, 1'b1); CHNL_TX = 1'b1; #1;
    total++; if (EVT_WR_EN !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got wr=%b want 0", EVT_WR_EN); end
    tick(1); #1;
    total++; if (EVT_WR_EN !== 1'b1 || EVT_DATA !== EVT_B2B_B) begin bad++; $display("FAIL b2b_second_open got wr=%b data=%h want 1 %h", EVT_WR_EN, EVT_DATA, EVT_B2B_B); end
    tick(2);
    CHNL_TX = 1'b0;
    tick(4);
    total++; if (wr_log.size() !== 9) begin bad++; $display("FAIL b2b_count got=%0d want=9", wr_log.size()); end
    total++; if (wr_log[0] !== EVT_B2B_A || wr_log[2] !== {1'b0, D0} || wr_log[4] !== EVT_B2B_A) begin bad++; $display("FAIL b2b_first got=%h %h %h want=%h", wr_log[0], wr_log[2], wr_log[4], EVT_B2B_A); end
    total++; if (wr_log[5] !== EVT_B2B_B || wr_log[6] !== EVT_B2B_B || wr_log[8] !== EVT_B2B_B) begin bad++; $display("FAIL b2b_second got=%h %h %h want=%h", wr_log[5], wr_log[6], wr_log[8], EVT_B2B_B); end
    total++; if (ack_cnt !== 2) begin bad++; $display("FAIL b2b_ack_count got=%0d want=2", ack_cnt); end
    total++; if (WORDS_SENT !== 32'd0) begin bad++; $display("FAIL b2b_words got=%0d want=0", WORDS_SENT); end
  endtask

  initial begin
    total = 0; bad = 0; ack_cnt = 0;
    RST = 1'b1; CHNL_TX = 1'b0; CHNL_TX_DATA_VALID = 1'b0; CHNL_TX_DATA = '0;
    EVT_FULL = 1'b0; CHNL_TX_LEN = '0; CHNL_TX_OFF = '0; CHNL_TX_LAST = 1'b0;
    test_reset();
    test_basic();
    test_full_stall();
    test_fall_with_beat();
    test_len_zero();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
